// File: rtl/ysyx_pkg.sv
// Shared definitions for the ysyx instruction fetch unit: FSM encoding, reset PC, word width.
package ysyx_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ysyx_ifu_if.sv
// Fetch-unit bus: instruction memory request/response, redirect, and decode handshake.
interface ysyx_ifu_if;
  import ysyx_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [31:0]       imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              jump_en;
  logic [31:0]       jump_addr;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [31:0]       pc;

  // The fetch unit drives requests and decoded instructions.
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, jump_en, jump_addr, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, jump_en, jump_addr, inst_ready
  );

endinterface

// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: one outstanding fetch, redirect with stale-response drop.
// Optional YSYX_IFU_MISALIGN_CHK_EN rejects misaligned redirects and flags them on misalign.
module ysyx_ifu
  import ysyx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef YSYX_IFU_MISALIGN_CHK_EN
  output logic       misalign,
`endif
  ysyx_ifu_if.master bus
);

  ifu_state_e        state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              drop_q, drop_d;
  logic              jump_ok;
  logic [31:0]       jump_tgt;

`ifdef YSYX_IFU_MISALIGN_CHK_EN
  assign misalign = bus.jump_en && (bus.jump_addr[1:0] != 2'b00);
  assign jump_ok  = bus.jump_en && (bus.jump_addr[1:0] == 2'b00);
  assign jump_tgt = bus.jump_addr;
`else
  assign jump_ok  = bus.jump_en;
  assign jump_tgt = bus.jump_addr & 32'hFFFF_FFFC;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    drop_d  = drop_q;
    unique case (state_q)
      S_REQ: begin
        if (jump_ok) pc_d = jump_tgt;
        // A redirect in the accept cycle makes the in-flight word stale.
        if (bus.imem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = jump_ok;
        end
      end
      S_WAIT: begin
        if (jump_ok) begin
          pc_d   = jump_tgt;
          drop_d = 1'b1;
        end
        if (bus.imem_rsp_valid) begin
          if (drop_q || jump_ok) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            inst_d  = bus.imem_rsp_data;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        // Redirect wins over a simultaneous decode handshake.
        if (jump_ok) begin
          pc_d    = jump_tgt;
          state_d = S_REQ;
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (state_q == S_OUT);
  assign bus.inst           = inst_q;
  assign bus.pc             = pc_q;

endmodule

// File: tb/tb_ysyx_ifu.sv
// Directed self-checking bench for ysyx_ifu; honours YSYX_IFU_MISALIGN_CHK_EN when defined.
module tb_ysyx_ifu;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
`ifdef YSYX_IFU_MISALIGN_CHK_EN
  logic misalign;
`endif

  ysyx_ifu_if bus ();

  ysyx_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef YSYX_IFU_MISALIGN_CHK_EN
    .misalign (misalign),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.jump_en        = 1'b0;
    bus.jump_addr      = '0;
    bus.inst_ready     = 1'b0;
  endtask

  // Request accepted, response one cycle later, word then held for decode.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, ".req_valid"}, 32'(bus.imem_req_valid), 32'd1);
    chk({tag, ".req_addr"}, bus.imem_req_addr, addr);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    chk({tag, ".wait_no_req"}, 32'(bus.imem_req_valid), 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk({tag, ".inst_valid"}, 32'(bus.inst_valid), 32'd1);
    chk({tag, ".inst"}, bus.inst, data);
    chk({tag, ".pc"}, bus.pc, addr);
  endtask

  task automatic consume();
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("rst.req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("rst.addr", bus.imem_req_addr, 32'h8000_0000);
    chk("rst.inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst.inst", bus.inst, 32'h0);

    // A response with no accepted request is ignored.
    rst_n = 1'b1;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("orphan.inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("orphan.req_valid", 32'(bus.imem_req_valid), 32'd1);

    // Sequential fetch.
    fetch("f0", 32'h8000_0000, 32'h0000_0013);
    consume();
    fetch("f1", 32'h8000_0004, 32'h0000_0013);
    consume();
    fetch("f2", 32'h8000_0008, 32'h0010_0093);

    // Decode stall holds the instruction.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall.inst_valid", 32'(bus.inst_valid), 32'd1);
      chk("stall.inst", bus.inst, 32'h0010_0093);
      chk("stall.pc", bus.pc, 32'h8000_0008);
      chk("stall.no_req", 32'(bus.imem_req_valid), 32'd0);
    end
    consume();
    chk("seq.addr3", bus.imem_req_addr, 32'h8000_000C);

    // Redirect while waiting: stale word dropped.
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.jump_en = 1'b1;
    bus.jump_addr = 32'h8000_1000;
    tick();
    bus.jump_en = 1'b0;
    chk("wjump.no_req", 32'(bus.imem_req_valid), 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD0_BAD0;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("wjump.inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("wjump.req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("wjump.addr", bus.imem_req_addr, 32'h8000_1000);

    // Redirect beats a simultaneous decode handshake.
    fetch("f3", 32'h8000_1000, 32'h1111_1111);
    bus.jump_en = 1'b1;
    bus.jump_addr = 32'h8000_2000;
    bus.inst_ready = 1'b1;
    tick();
    clear_in();
    chk("ojump.inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("ojump.req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("ojump.addr", bus.imem_req_addr, 32'h8000_2000);

    // Redirect in the accept cycle: the response for the old PC is dropped.
    bus.jump_en = 1'b1;
    bus.jump_addr = 32'h8000_3000;
    bus.imem_req_ready = 1'b1;
    tick();
    clear_in();
    chk("rjump.no_req", 32'(bus.imem_req_valid), 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD1_BAD1;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("rjump.inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rjump.addr", bus.imem_req_addr, 32'h8000_3000);

    // Redirect together with the response.
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.jump_en = 1'b1;
    bus.jump_addr = 32'h8000_5000;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD2_BAD2;
    tick();
    clear_in();
    chk("cjump.inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("cjump.req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("cjump.addr", bus.imem_req_addr, 32'h8000_5000);

    // PC wraps past the top of the address space.
    bus.jump_en = 1'b1;
    bus.jump_addr = 32'hFFFF_FFFC;
    tick();
    clear_in();
    fetch("fwrap", 32'hFFFF_FFFC, 32'h2222_2222);
    consume();
    chk("wrap.addr", bus.imem_req_addr, 32'h0000_0000);

    // Misaligned redirect.
    bus.jump_en = 1'b1;
    bus.jump_addr = 32'h8000_0002;
    #1;
`ifdef YSYX_IFU_MISALIGN_CHK_EN
    chk("mis.pulse", 32'(misalign), 32'd1);
`endif
    tick();
    clear_in();
    #1;
`ifdef YSYX_IFU_MISALIGN_CHK_EN
    chk("mis.clear", 32'(misalign), 32'd0);
    chk("mis.addr", bus.imem_req_addr, 32'h0000_0000);
`else
    chk("mis.addr", bus.imem_req_addr, 32'h8000_0000);
`endif

    // Reset while a request is outstanding.
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst.req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("mrst.addr", bus.imem_req_addr, 32'h8000_0000);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD3_BAD3;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("mrst.inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("mrst.req_again", 32'(bus.imem_req_valid), 32'd1);
    chk("mrst.inst", bus.inst, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
